// File: rtl/fw_local_intc_ext_wb.sv
// fw_local_intc_ext_wb: Wishbone-attached local interrupt controller.
// Handles up to 32 sources with per-source enable, edge/level mode, sticky
// W1C pending bits for edge sources, and a claim register that returns the
// lowest-numbered active source (index+1, 0 when none).
// Optional macro FW_LOCAL_INTC_SYNC_EN adds a 2-flop synchroniser on src.
`timescale 1ns/1ps
module fw_local_intc_ext_wb #(
  parameter int unsigned N_SRCS   = 8,
  parameter logic [31:0] EN_RST   = 32'h0,
  parameter logic [31:0] MODE_RST = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        adr,
  input  logic [31:0]       dat_w,
  output logic [31:0]       dat_r,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [3:0]        sel,
  output logic              ack,
  input  logic [N_SRCS-1:0] src,
  output logic              irq
);

  typedef enum logic {IDLE, ACK} busState_t;

  busState_t         r_state;
  logic [31:0]       r_datR;
  logic              r_ack;
  logic              r_irq;
  logic [N_SRCS-1:0] r_pending;
  logic [N_SRCS-1:0] r_enable;
  logic [N_SRCS-1:0] r_mode;
  logic [N_SRCS-1:0] r_srcQ;

  logic [N_SRCS-1:0] w_srcS;
  logic [N_SRCS-1:0] w_rise;
  logic [31:0]       w_byteMask;
  logic [N_SRCS-1:0] w_laneMask;
  logic [N_SRCS-1:0] w_wrBits;
  logic [N_SRCS-1:0] w_w1c;
  logic [N_SRCS-1:0] w_claimClr;
  logic [N_SRCS-1:0] w_active;
  logic [N_SRCS-1:0] w_claimHot;
  logic [N_SRCS-1:0] w_edgeNext;
  logic [N_SRCS-1:0] w_pendingNext;
  logic [5:0]        w_claimId;
  logic [31:0]       w_rdData;
  logic              w_access;
  logic              w_wrPending;
  logic              w_wrEnable;
  logic              w_wrMode;
  logic              w_rdClaim;
  logic              w_unusedBits;

`ifdef FW_LOCAL_INTC_SYNC_EN
  logic [N_SRCS-1:0] r_sync1;
  logic [N_SRCS-1:0] r_sync2;

  // Two-flop synchroniser so asynchronous sources are safe to sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_srcS = r_sync2;
`else
  assign w_srcS = src;
`endif

  // An access happens only on the IDLE edge; a held strobe in ACK is ignored
  assign w_access    = (r_state == IDLE) && cyc && stb;
  assign w_wrPending = w_access && we  && (adr[3:2] == 2'd0);
  assign w_wrEnable  = w_access && we  && (adr[3:2] == 2'd1);
  assign w_wrMode    = w_access && we  && (adr[3:2] == 2'd2);
  assign w_rdClaim   = w_access && !we && (adr[3:2] == 2'd3);

  assign w_byteMask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  assign w_laneMask = w_byteMask[N_SRCS-1:0];
  assign w_wrBits   = dat_w[N_SRCS-1:0] & w_laneMask;

  assign w_rise     = w_srcS & ~r_srcQ;
  assign w_active   = r_pending & r_enable;
  assign w_w1c      = w_wrPending ? w_wrBits : '0;
  assign w_claimClr = w_rdClaim ? w_claimHot : '0;

  // Edge bits: clear then set, so a new edge wins over a same-cycle clear
  assign w_edgeNext    = (r_pending & ~(w_w1c | w_claimClr)) | w_rise;
  assign w_pendingNext = (r_mode & w_edgeNext) | (~r_mode & w_srcS);

  assign w_unusedBits = ^{adr[1:0], dat_w, w_byteMask};

  // Priority encoder: scanning downward leaves the lowest active index
  always_comb begin
    w_claimId  = 6'd0;
    w_claimHot = '0;
    for (int i = N_SRCS - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_claimId     = 6'(i + 1);
        w_claimHot    = '0;
        w_claimHot[i] = 1'b1;
      end
    end
  end

  // Read mux, zero-extending the N_SRCS-wide registers
  always_comb begin
    w_rdData = 32'h0;
    case (adr[3:2])
      2'd0:    w_rdData = 32'(r_pending);
      2'd1:    w_rdData = 32'(r_enable);
      2'd2:    w_rdData = 32'(r_mode);
      default: w_rdData = 32'(w_claimId);
    endcase
  end

  // Interrupt state: source history, pending, enable/mode and the irq line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_srcQ    <= '0;
      r_pending <= '0;
      r_enable  <= EN_RST[N_SRCS-1:0];
      r_mode    <= MODE_RST[N_SRCS-1:0];
      r_irq     <= 1'b0;
    end else begin
      r_srcQ    <= w_srcS;
      r_pending <= w_pendingNext;
      r_irq     <= |(r_pending & r_enable);
      if (w_wrEnable) r_enable <= (r_enable & ~w_laneMask) | w_wrBits;
      if (w_wrMode)   r_mode   <= (r_mode & ~w_laneMask) | w_wrBits;
    end
  end

  // Bus handshake: one-cycle ack per access, read data captured at access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_datR  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cyc && stb) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_datR  <= w_rdData;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign dat_r = r_datR;
  assign irq   = r_irq;

endmodule

// File: tb/tb_fw_local_intc_ext_wb.sv
// tb_fw_local_intc_ext_wb: directed self-checking bench for the local intc.
`timescale 1ns/1ps
module tb_fw_local_intc_ext_wb;

`ifdef FW_LOCAL_INTC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [3:0] A_PEND  = 4'h0;
  localparam logic [3:0] A_EN    = 4'h4;
  localparam logic [3:0] A_MODE  = 4'h8;
  localparam logic [3:0] A_CLAIM = 4'hC;

  logic        clock;
  logic        reset;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        ack;
  logic [7:0]  src;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  fw_local_intc_ext_wb #(.N_SRCS(8), .EN_RST(32'h0), .MODE_RST(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .adr   (adr),
    .dat_w (dat_w),
    .dat_r (dat_r),
    .cyc   (cyc),
    .stb   (stb),
    .we    (we),
    .sel   (sel),
    .ack   (ack),
    .src   (src),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete Wishbone access: strobe, ack edge, release, idle edge
  task automatic applyStimulus(input logic doWrite, input logic [3:0] addr,
                               input logic [31:0] data, input logic [3:0] lanes,
                               output logic [31:0] rdata);
    cyc = 1'b1; stb = 1'b1; we = doWrite; adr = addr; dat_w = data; sel = lanes;
    tick();
    checkOutput("ackHigh", {31'h0, ack}, 32'h1);
    rdata = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    checkOutput("ackLow", {31'h0, ack}, 32'h0);
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] lanes);
    logic [31:0] dummy;
    applyStimulus(1'b1, addr, data, lanes, dummy);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    applyStimulus(1'b0, addr, 32'h0, 4'hF, got);
    checkOutput(tag, got, exp);
  endtask

  // Drive a one-cycle source pulse and wait until it reaches pending
  task automatic pulseSrc(input logic [7:0] bits);
    src = bits;
    tick();
    src = 8'h00;
    repeat (1 + SYNC_LAT) tick();
  endtask

  initial begin
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 4'h0; dat_w = 32'h0; sel = 4'h0; src = 8'h00;
    #1;
    checkOutput("rstAck", {31'h0, ack}, 32'h0);
    checkOutput("rstIrq", {31'h0, irq}, 32'h0);
    checkOutput("rstDatR", dat_r, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    tick();

    $display("[TB] reset values");
    readCheck("rstPend", A_PEND, 32'h0);
    readCheck("rstEn", A_EN, 32'h0);
    readCheck("rstMode", A_MODE, 32'h0);
    readCheck("rstClaim", A_CLAIM, 32'h0);

    $display("[TB] edge pulse, claim clears");
    writeReg(A_EN, 32'h01, 4'hF);
    writeReg(A_MODE, 32'h01, 4'hF);
    src = 8'h01;
    tick();
    src = 8'h00;
    repeat (SYNC_LAT) tick();
    checkOutput("irqNotYet", {31'h0, irq}, 32'h0);
    tick();
    checkOutput("irqRaised", {31'h0, irq}, 32'h1);
    readCheck("edgePend", A_PEND, 32'h1);
    readCheck("claimSrc0", A_CLAIM, 32'h1);
    checkOutput("irqAfterClaim", {31'h0, irq}, 32'h0);
    readCheck("pendCleared", A_PEND, 32'h0);

    $display("[TB] level mode");
    writeReg(A_MODE, 32'h00, 4'hF);
    writeReg(A_EN, 32'h04, 4'hF);
    src = 8'h04;
    repeat (1 + SYNC_LAT) tick();
    readCheck("levelClaimA", A_CLAIM, 32'h3);
    readCheck("levelClaimB", A_CLAIM, 32'h3);
    writeReg(A_PEND, 32'h04, 4'hF);
    readCheck("levelNoW1c", A_PEND, 32'h4);
    checkOutput("levelIrq", {31'h0, irq}, 32'h1);
    src = 8'h00;
    repeat (2 + SYNC_LAT) tick();
    checkOutput("levelIrqLow", {31'h0, irq}, 32'h0);
    readCheck("levelPendLow", A_PEND, 32'h0);

    $display("[TB] claim priority");
    writeReg(A_MODE, 32'hFF, 4'hF);
    writeReg(A_EN, 32'h22, 4'hF);
    pulseSrc(8'h22);
    readCheck("claimFirst", A_CLAIM, 32'h2);
    readCheck("claimSecond", A_CLAIM, 32'h6);
    readCheck("claimNone", A_CLAIM, 32'h0);

    $display("[TB] disabled source latches pending");
    writeReg(A_EN, 32'h00, 4'hF);
    pulseSrc(8'h08);
    readCheck("disPend", A_PEND, 32'h08);
    checkOutput("disIrq", {31'h0, irq}, 32'h0);
    writeReg(A_EN, 32'h08, 4'hF);
    checkOutput("enableIrq", {31'h0, irq}, 32'h1);
    writeReg(A_PEND, 32'h08, 4'b0010);
    readCheck("w1cWrongLane", A_PEND, 32'h08);
    writeReg(A_PEND, 32'h08, 4'hF);
    readCheck("w1cClear", A_PEND, 32'h00);

    $display("[TB] set wins over W1C");
    pulseSrc(8'h01);
    readCheck("collPre", A_PEND, 32'h01);
    src = 8'h01;
    repeat (SYNC_LAT) tick();
    writeReg(A_PEND, 32'h01, 4'hF);
    readCheck("collSetWins", A_PEND, 32'h01);
    writeReg(A_PEND, 32'h01, 4'hF);
    readCheck("collLaterClear", A_PEND, 32'h00);
    src = 8'h00;
    tick();

    $display("[TB] back-to-back strobe");
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_EN; dat_w = 32'hFFFF_FFFF; sel = 4'b0001;
    checkOutput("b2b0", {31'h0, ack}, 32'h0);
    tick();
    checkOutput("b2b1", {31'h0, ack}, 32'h1);
    tick();
    checkOutput("b2b2", {31'h0, ack}, 32'h0);
    tick();
    checkOutput("b2b3", {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    checkOutput("b2bEnd", {31'h0, ack}, 32'h0);
    readCheck("enMasked", A_EN, 32'h0000_00FF);
    writeReg(A_CLAIM, 32'hFFFF_FFFF, 4'hF);
    readCheck("modeKept", A_MODE, 32'h0000_00FF);

    $display("[TB] reset mid-access");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_EN; sel = 4'hF;
    tick();
    checkOutput("midAck", {31'h0, ack}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midRstAck", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    readCheck("postRstEn", A_EN, 32'h0);
    readCheck("postRstMode", A_MODE, 32'h0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
